// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide/remainder unit.
package div_pkg;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } div_state_t;

   localparam logic [31:0] DIV_BY_ZERO_Q = '1;
   localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract
// the divisor, keep the difference and set the quotient bit when it fits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic           fits;

   // Partial remainder can briefly need WIDTH+1 bits after the shift; once the
   // divisor is subtracted (or not) it always fits back in WIDTH bits.
   always_comb begin
      shifted = {rem_i, quo_i[WIDTH-1]};
      fits    = (shifted >= {1'b0, divisor_i});
      rem_o   = fits ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
      quo_o   = {quo_i[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/div_unit.sv
// Multicycle RV32M DIV/DIVU/REM/REMU responder on the start/complete handshake.
//
// state | meaning
// IDLE  | waiting for div strobe; operands latched on accept
// PREP  | take magnitudes, record signs, detect divide-by-zero / overflow
// CALC  | one restoring iteration per cycle, WIDTH cycles
// FIX   | apply sign / special-case result, register result4
// DONE  | complete4 high for this cycle, then back to IDLE
module div_unit
   import div_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       funct3,
   input  logic             div,
   output logic [WIDTH-1:0] result4,
   output logic             complete4,
   output logic             busy
);

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] x_q, y_q, quo_q, rem_q, result_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op_q;
   logic             q_neg_q, r_neg_q, dz_q, ovf_q;
   logic             complete_q, busy_q;

   logic             is_signed, is_rem, dz_now, ovf_now;
   logic [WIDTH-1:0] abs_x, abs_y, fix_result;
   logic [WIDTH-1:0] step_rem, step_quo;

   // Only bits 1:0 select the operation; bit 2 is always 1 for this unit.
   logic unused_f3_msb;
   assign unused_f3_msb = funct3[2];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (y_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   // Operand decode, magnitudes, special-case detection and final result select.
   always_comb begin
      is_signed = (op_q == F3_DIV[1:0]) || (op_q == F3_REM[1:0]);
      is_rem    = (op_q == F3_REM[1:0]) || (op_q == F3_REMU[1:0]);
      abs_x     = (is_signed && x_q[WIDTH-1]) ? -x_q : x_q;
      abs_y     = (is_signed && y_q[WIDTH-1]) ? -y_q : y_q;
      dz_now    = (y_q == '0);
      ovf_now   = is_signed && (x_q == WIDTH'(INT_MIN)) && (y_q == '1);
      if (dz_q) begin
         fix_result = is_rem ? x_q : WIDTH'(DIV_BY_ZERO_Q);
      end else if (ovf_q) begin
         fix_result = is_rem ? '0 : WIDTH'(INT_MIN);
      end else if (is_rem) begin
         fix_result = r_neg_q ? -rem_q : rem_q;
      end else begin
         fix_result = q_neg_q ? -quo_q : quo_q;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (div) state_d = PREP;
         PREP:    state_d = (dz_now || ovf_now) ? FIX : CALC;
         CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Operand latches, iteration datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q        <= '0;
         y_q        <= '0;
         op_q       <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         dz_q       <= 1'b0;
         ovf_q      <= 1'b0;
         result_q   <= '0;
         complete_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (div) begin
                  x_q  <= x;
                  y_q  <= y;
                  op_q <= funct3[1:0];
               end
            end
            PREP: begin
               quo_q   <= abs_x;
               rem_q   <= '0;
               cnt_q   <= '0;
               y_q     <= abs_y;
               q_neg_q <= is_signed && (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
               r_neg_q <= is_signed && x_q[WIDTH-1];
               dz_q    <= dz_now;
               ovf_q   <= ovf_now;
            end
            CALC: begin
               quo_q <= step_quo;
               rem_q <= step_rem;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            FIX:     result_q <= fix_result;
            default: ;
         endcase
         complete_q <= (state_q == FIX);
         busy_q     <= (state_d != IDLE);
      end
   end

   assign result4   = result_q;
   assign complete4 = complete_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, special cases,
// ignored restarts and mid-operation reset.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] x, y;
   logic [2:0]  funct3;
   logic        div;
   logic [31:0] result4;
   logic        complete4;
   logic        busy;

   int n_checks = 0;
   int n_err    = 0;

   div_unit dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .y         (y),
      .funct3    (funct3),
      .div       (div),
      .result4   (result4),
      .complete4 (complete4),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, then scramble operands and verify latency, result and busy/complete timing.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string tag);
      int  n;
      bit  seen;
      @(negedge clk);
      funct3 = f3; x = a; y = b; div = 1'b1;
      @(posedge clk); #1;
      div = 1'b0; x = $urandom; y = $urandom; funct3 = 3'($urandom);
      chk({tag, " busy_after_start"}, {31'b0, busy}, 32'd1);
      n = 0; seen = 0;
      while (!seen && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (complete4) seen = 1;
      end
      chk({tag, " latency"}, n, exp_lat);
      chk({tag, " result"}, result4, exp);
      @(posedge clk); #1;
      chk({tag, " complete_drop"}, {31'b0, complete4}, 32'd0);
      chk({tag, " busy_drop"}, {31'b0, busy}, 32'd0);
      chk({tag, " result_hold"}, result4, exp);
   endtask

   initial begin
      int  pulses, lat;
      logic [31:0] res;

      rst = 1'b1; div = 1'b0; x = '0; y = '0; funct3 = 3'b100;
      repeat (2) @(posedge clk);
      #1;
      chk("reset result4", result4, 32'd0);
      chk("reset complete4", {31'b0, complete4}, 32'd0);
      chk("reset busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;

      run_op(3'b101, 32'd100, 32'd7, 32'h0000_000E, 34, "divu_100_7");
      run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, "div_m100_7");
      run_op(3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, "rem_m100_7");
      run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
      run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");
      run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, "rem_7_m2");
      run_op(3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34, "rem_m7_m2");
      run_op(3'b100, 32'h8000_0000, 32'd2, 32'hC000_0000, 34, "div_min_2");
      run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "divu_max_1");
      run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "divu_min_m1");
      run_op(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "remu_min_m1");

      run_op(3'b100, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 2, "div_by0");
      run_op(3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 2, "divu_by0");
      run_op(3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678, 2, "rem_by0");
      run_op(3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678, 2, "remu_by0");
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf");

      // Restart attempts at k+5 and during DONE must be ignored.
      @(negedge clk);
      funct3 = 3'b101; x = 32'd1000; y = 32'd10; div = 1'b1;
      @(posedge clk); #1;
      div = 1'b0; x = 32'd77; y = 32'd0;
      pulses = 0; lat = 0; res = '0;
      for (int c = 1; c <= 45; c++) begin
         if (c == 5)  begin div = 1'b1; x = 32'd5; y = 32'd1; funct3 = 3'b100; end
         if (c == 6)  div = 1'b0;
         if (c == 35) begin div = 1'b1; x = 32'd9; y = 32'd3; end
         if (c == 36) div = 1'b0;
         @(posedge clk); #1;
         if (complete4) begin
            pulses++;
            if (lat == 0) begin lat = c; res = result4; end
         end
      end
      chk("restart pulses", pulses, 32'd1);
      chk("restart latency", lat, 32'd34);
      chk("restart result", res, 32'd100);
      chk("restart busy_idle", {31'b0, busy}, 32'd0);
      chk("restart result_hold", result4, 32'd100);

      // Reset at edge k+10 aborts the operation without a completion pulse.
      @(negedge clk);
      funct3 = 3'b101; x = 32'd1000; y = 32'd3; div = 1'b1;
      @(posedge clk); #1;
      div = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort result4", result4, 32'd0);
      chk("abort busy", {31'b0, busy}, 32'd0);
      chk("abort complete4", {31'b0, complete4}, 32'd0);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (complete4) pulses++;
      end
      chk("abort no_pulse", pulses, 32'd0);
      run_op(3'b101, 32'd9, 32'd3, 32'd3, 34, "divu_9_3_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle RV32M divide/remainder functional unit (DIV, DIVU, REM, REMU).
- Sits beside mul, mulhsu and lui as a responder to the controller's start/complete handshake.
- Latches operands on a one-cycle start strobe, runs a radix-2 restoring division, and returns a registered result with a one-cycle complete pulse.

Parameters:
- WIDTH, 32: operand and result width.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; not to be overridden).

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- x  input  WIDTH  dividend (rs1); sampled only on an accepted start
- y  input  WIDTH  divisor (rs2); sampled only on an accepted start
- funct3  input  3  op select: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU; sampled with x/y
- div  input  1  start strobe from controller
- result4  output  WIDTH  quotient or remainder; registered; held until next accepted start
- complete4  output  1  one-cycle pulse, result4 valid in the same cycle
- busy  output  1  high from the cycle after an accepted start until complete4 deasserts

Behaviour:
- Reset: synchronous, active-high.
  - rst=1 at an edge forces state IDLE, result4=0, complete4=0, busy=0; counter and working registers are cleared.
  - rst mid-operation aborts with no complete4 pulse.
  - rst and div together: rst wins.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - div=1 at edge k latches x, y and funct3 and moves to PREP.
  - div is ignored in every other state; no queuing.
  - funct3 values other than 1xx are undefined; div_unit treats bit 2 as don't-care and decodes bits 1:0 only.
- PREP (edge k+1):
  - Signed ops: take magnitudes of x and y; record q_neg = x[31]^y[31] and r_neg = x[31].
  - Unsigned ops: q_neg = r_neg = 0.
  - Clear remainder and counter; load quotient register with |x|.
  - If y==0, or signed op with x=0x80000000 and y=0xFFFFFFFF, set special and go to FIX. Otherwise go to CALC.
- CALC, one iteration per cycle for WIDTH cycles (edges k+2..k+33):
  - Shift {rem,quo} left by 1.
  - Trial-subtract |y| (WIDTH+1-bit subtract).
  - If non-negative: keep the difference and set quo[0]=1.
  - Counter reaching WIDTH-1 moves to FIX.
- FIX, registers result4:
  - Normal: quotient op gives q_neg ? -quo : quo; remainder op gives r_neg ? -rem : rem.
  - Divide by zero: quotient op gives 0xFFFFFFFF (signed and unsigned); remainder op gives x.
  - Overflow: DIV gives 0x80000000; REM gives 0.
  - Sets complete4=1 and moves to DONE.
- DONE: complete4 is high for this single cycle; next edge clears complete4 and busy and returns to IDLE.
  - div asserted during DONE is ignored. The controller must wait for complete4 before re-issuing.
- Latency (start edge k to complete4-high cycle):
  - Normal: complete4 rises after edge k+34.
  - Special cases: complete4 rises after edge k+2.
- Reuse: result4 is stable from complete4 until the next accepted start, so the controller may sample late. x, y and funct3 may change freely after the start edge.
- Arithmetic: all negation is two's complement modulo 2^WIDTH. Remainder sign follows dividend and quotient truncates toward zero, per RV32M.

Decomposition:
- Shared package div_pkg:
  - funct3 localparams F3_DIV, F3_DIVU, F3_REM, F3_REMU.
  - State enum div_state_t {IDLE, PREP, CALC, FIX, DONE}.
  - Special-value constants DIV_BY_ZERO_Q = '1 and INT_MIN = 32'h8000_0000.
- One sub-module, div_step: purely combinational single restoring iteration. Inputs rem, quo, divisor; outputs next rem and next quo. Keeps the CALC datapath separately testable.
- FSM, operand latches and sign fix-up stay in div_unit.

Test Plan:
- DIVU x=100, y=7, div pulse at edge k -> busy=1 from k+1; complete4 one-cycle pulse after edge k+34 with result4=14 (0x0000000E); busy=0 after edge k+35.
- DIV x=-100 (0xFFFFFF9C), y=7 -> result4=0xFFFFFFF2 (-14); REM same operands -> result4=0xFFFFFFFE (-2); REMU x=100, y=7 -> 2.
- Divide by zero, x=0x12345678, y=0 -> DIV and DIVU give 0xFFFFFFFF, REM and REMU give 0x12345678; each completes after edge k+2.
- Overflow DIV x=0x80000000, y=0xFFFFFFFF -> result4=0x80000000 after edge k+2; REM -> 0.
- div re-pulsed at k+5 and during DONE, with x/y changed after k -> ignored; first result unaffected; exactly one complete4 pulse.
- rst asserted at edge k+10 mid-CALC -> result4=0, busy=0, no complete4. A fresh DIVU 9/3 issued afterwards returns 3 after 34 edges.
